// File: rtl/seq_detect_arbiter.sv
// Round-robin shared "1011" Moore detector across NCH serial channels with per-channel state.
// Optional per-channel saturating detection counters are enabled by defining SEQ_DET_ARB_COUNT_EN.
module seq_detect_arbiter #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NCH-1:0]         ch_valid,
  input  logic [NCH-1:0]         ch_bit,
  output logic [NCH-1:0]         ch_ready,
  output logic                   det_valid,
  output logic [$clog2(NCH)-1:0] det_ch,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       cnt_data
);

  localparam int IDX_W = $clog2(NCH);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  logic [2:0]       state_q [NCH];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  logic             gnt_p0;
  logic [IDX_W-1:0] gnt_idx_p0;
  logic [2:0]       cur_st_p0;
  logic             cur_bit_p0;
  state_e           nxt_st_p0;
  logic             hit_p0;

  logic             vld_p1;
  logic [IDX_W-1:0] det_ch_p1;

  function automatic int rr_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NCH) s = s - NCH;
    return s;
  endfunction

  // Stage p0: arbitration, searching forward from ptr with wrap.
  always_comb begin
    ch_ready   = '0;
    gnt_p0     = 1'b0;
    gnt_idx_p0 = '0;
    if (en && !reset) begin
      for (int k = 0; k < NCH; k++) begin
        if (!gnt_p0 && ch_valid[rr_idx(int'(ptr_q), k)]) begin
          gnt_p0     = 1'b1;
          gnt_idx_p0 = IDX_W'(rr_idx(int'(ptr_q), k));
        end
      end
      ch_ready[gnt_idx_p0] = gnt_p0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_p0) begin
      if (int'(gnt_idx_p0) == NCH - 1) ptr_d = '0;
      else                             ptr_d = gnt_idx_p0 + IDX_W'(1);
    end
  end

  // Shared next-state logic applied to the granted channel only; S4 and illegal codes fall to S0.
  always_comb begin
    cur_st_p0  = state_q[gnt_idx_p0];
    cur_bit_p0 = ch_bit[gnt_idx_p0];
    nxt_st_p0  = S0;
    hit_p0     = 1'b0;
    case (cur_st_p0)
      S0:      nxt_st_p0 = cur_bit_p0 ? S1 : S0;
      S1:      nxt_st_p0 = cur_bit_p0 ? S1 : S2;
      S2:      nxt_st_p0 = cur_bit_p0 ? S3 : S0;
      S3: begin
        nxt_st_p0 = cur_bit_p0 ? S4 : S2;
        hit_p0    = cur_bit_p0 & gnt_p0;
      end
      default: nxt_st_p0 = S0;
    endcase
  end

  // Stage p1: state file write-back and registered detection pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) state_q[k] <= S0;
      ptr_q     <= '0;
      vld_p1    <= 1'b0;
      det_ch_p1 <= '0;
    end else begin
      if (gnt_p0) state_q[gnt_idx_p0] <= nxt_st_p0;
      ptr_q  <= ptr_d;
      vld_p1 <= hit_p0;
      if (hit_p0) det_ch_p1 <= gnt_idx_p0;
    end
  end

  assign det_valid = vld_p1;
  assign det_ch    = det_ch_p1;

`ifdef SEQ_DET_ARB_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  // Stage p2: counters follow the registered pulse; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_clr && int'(cnt_sel) == k)
          cnt_q[k] <= '0;
        else if (vld_p1 && int'(det_ch_p1) == k && cnt_q[k] != '1)
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_data = '0;
    for (int k = 0; k < NCH; k++)
      if (int'(cnt_sel) == k) cnt_data = cnt_q[k];
  end
`else
  logic cnt_unused;
  assign cnt_unused = ^{cnt_sel, cnt_clr};
  assign cnt_data   = '0;
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: detections are queued at drive time and matched against det_valid pulses.
module tb_seq_detect_arbiter;

  localparam int NCH = 4;
`ifdef SEQ_DET_ARB_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b1;
  logic [NCH-1:0]   ch_valid = '0;
  logic [NCH-1:0]   ch_bit = '0;
  logic [NCH-1:0]   ch_ready;
  logic             det_valid;
  logic [1:0]       det_ch;
  logic [1:0]       cnt_sel = '0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_data;

  typedef struct {
    int cyc;
    int ch;
  } det_t;

  det_t exp_q[$];
  det_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_detect_arbiter #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(ch_ready), .det_valid(det_valid), .det_ch(det_ch),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_data(cnt_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the head of the queue, and no expected pulse may be skipped.
  always @(negedge clk) begin
    if (det_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL det_unexpected: got det_valid=1 det_ch=%0d at cycle %0d, required no pulse", det_ch, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || int'(det_ch) != mon_e.ch) begin
          errors++;
          $display("FAIL det_match: got cycle %0d ch %0d, required cycle %0d ch %0d", cyc, det_ch, mon_e.cyc, mon_e.ch);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL det_missed: got no pulse at cycle %0d, required ch %0d at cycle %0d", cyc, exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; en = 1'b1; ch_valid = '0; ch_bit = '0; cnt_clr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    ch_valid = '0;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending detections, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; ch_valid = '1; ch_bit = '1;
    tick(); tick();
    checks++;
    if (ch_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b, required 0000", ch_ready); end
    checks++;
    if (det_valid !== 1'b0) begin errors++; $display("FAIL reset_det_valid: got %b, required 0", det_valid); end
    checks++;
    if (det_ch !== 2'd0) begin errors++; $display("FAIL reset_det_ch: got %0d, required 0", det_ch); end
    checks++;
    if (cnt_data !== '0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", cnt_data); end
    reset = 1'b0; ch_valid = '0; ch_bit = '0;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] pat = 4'b1011;
    apply_reset();
    ch_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      ch_bit[0] = pat[3-k];
      #1;
      checks++;
      if (ch_ready !== 4'b0001) begin errors++; $display("FAIL single_ready%0d: got %b, required 0001", k, ch_ready); end
      if (k == 3) exp_q.push_back('{cyc: cyc + 1, ch: 0});
      tick();
    end
    drain("single");
    checks++;
    if (det_ch !== 2'd0) begin errors++; $display("FAIL single_hold: got det_ch %0d, required 0", det_ch); end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] pat = 8'b1011_1011;
    apply_reset();
    ch_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      ch_bit[2] = pat[7-k];
      #1;
      checks++;
      if (ch_ready !== 4'b0100) begin errors++; $display("FAIL nonoverlap_ready%0d: got %b, required 0100", k, ch_ready); end
      if (k == 3) exp_q.push_back('{cyc: cyc + 1, ch: 2});
      tick();
    end
    drain("nonoverlap");
  endtask

  task automatic test_round_robin();
    logic [3:0] pat = 4'b1011;
    logic [3:0] want;
    apply_reset();
    ch_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      ch_bit = pat[3-k/4] ? 4'b1111 : 4'b0000;
      want = 4'b0001 << (k % 4);
      #1;
      checks++;
      if (ch_ready !== want) begin errors++; $display("FAIL rr_ready%0d: got %b, required %b", k, ch_ready, want); end
      if (k >= 12) exp_q.push_back('{cyc: cyc + 1, ch: k % 4});
      tick();
    end
    drain("rr");
    checks++;
    if (det_ch !== 2'd3) begin errors++; $display("FAIL rr_hold: got det_ch %0d, required 3", det_ch); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre = 3'b101;
    logic [4:0] post = 5'b11011;
    apply_reset();
    ch_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      ch_bit[1] = pre[2-k];
      tick();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ch_ready !== 4'b0000) begin errors++; $display("FAIL midreset_ready: got %b, required 0000", ch_ready); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ch_bit[1] = post[4-k];
      #1;
      checks++;
      if (ch_ready !== 4'b0010) begin errors++; $display("FAIL midreset_ready%0d: got %b, required 0010", k, ch_ready); end
      if (k == 4) exp_q.push_back('{cyc: cyc + 1, ch: 1});
      tick();
    end
    drain("midreset");
  endtask

  task automatic test_en_wrap();
    logic [2:0] pre = 3'b101;
    logic [3:0] order [3];
    order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b1000;
    apply_reset();
    ch_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      ch_bit[0] = pre[2-k];
      tick();
    end
    en = 1'b0; ch_bit[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (ch_ready !== 4'b0000) begin errors++; $display("FAIL freeze_ready%0d: got %b, required 0000", k, ch_ready); end
      tick();
    end
    en = 1'b1;
    #1;
    exp_q.push_back('{cyc: cyc + 1, ch: 0});
    tick();
    ch_valid = 4'b0100; ch_bit = '0;
    #1;
    checks++;
    if (ch_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b, required 0100", ch_ready); end
    tick();
    ch_valid = 4'b1001; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ch_ready !== 4'b0000) begin errors++; $display("FAIL en_gate%0d: got %b, required 0000", k, ch_ready); end
      tick();
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ch_ready !== order[k]) begin errors++; $display("FAIL wrap_order%0d: got %b, required %b", k, ch_ready, order[k]); end
      tick();
    end
    drain("enwrap");
  endtask

  task automatic send_group(input logic clr_on_det);
    logic [4:0] pat = 5'b01011;
    ch_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      ch_bit[0] = pat[4-k];
      if (k == 4) exp_q.push_back('{cyc: cyc + 1, ch: 0});
      tick();
    end
    ch_valid = '0;
    cnt_clr = clr_on_det;
    tick();
    cnt_clr = 1'b0;
    tick();
  endtask

  task automatic test_counter();
    apply_reset();
    cnt_sel = 2'd0;
`ifdef SEQ_DET_ARB_COUNT_EN
    send_group(1'b0);
    #1;
    checks++;
    if (cnt_data !== 2'd1) begin errors++; $display("FAIL cnt_one: got %0d, required 1", cnt_data); end
    for (int r = 0; r < 4; r++) send_group(1'b0);
    #1;
    checks++;
    if (cnt_data !== 2'd3) begin errors++; $display("FAIL cnt_sat: got %0d, required 3", cnt_data); end
    cnt_sel = 2'd1;
    #1;
    checks++;
    if (cnt_data !== 2'd0) begin errors++; $display("FAIL cnt_other: got %0d, required 0", cnt_data); end
    cnt_sel = 2'd0;
    send_group(1'b1);
    #1;
    checks++;
    if (cnt_data !== 2'd0) begin errors++; $display("FAIL cnt_clr_sat: got %0d, required 0", cnt_data); end
    send_group(1'b1);
    #1;
    checks++;
    if (cnt_data !== 2'd0) begin errors++; $display("FAIL cnt_clr_wins: got %0d, required 0", cnt_data); end
    send_group(1'b0);
    #1;
    checks++;
    if (cnt_data !== 2'd1) begin errors++; $display("FAIL cnt_resume: got %0d, required 1", cnt_data); end
`else
    send_group(1'b0);
    #1;
    checks++;
    if (cnt_data !== '0) begin errors++; $display("FAIL cnt_tied: got %0d, required 0", cnt_data); end
`endif
    drain("counter");
  endtask

  initial begin
    test_reset();
    test_single();
    test_nonoverlap();
    test_round_robin();
    test_reset_mid();
    test_en_wrap();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
